imem_responder: RTL

- Instruction-memory responder: the memory end of the CPU's fetch interface. It accepts a fetch address (pc) and returns the 32-bit instruction word.
- Holds a word-addressed instruction store mapped at BASE_ADDR. The store is preloaded through a side write port.
- Handshake on both the request and response channels, with configurable access latency, so the core can later move from an ideal single-cycle fetch to a realistic stalled fetch.

---
 rtl/imem_responder_pkg.sv | 33 +++
 rtl/imem_responder_if.sv | 26 ++
 rtl/imem_responder_array.sv | 34 +++
 rtl/imem_responder.sv | 119 +++++++++++
 4 files changed

// File: rtl/imem_responder_pkg.sv
// Shared definitions for the instruction-memory responder: FSM states, the
// fetch address map and the address-to-word-index/range-check helper.
package imem_responder_pkg;

    localparam logic [31:0] PC_RESET = 32'h8000_0000;
    localparam int unsigned INST_W   = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic        err;
        logic [31:0] idx;
    } addr_map_t;

    // Below-base addresses are caught by the compare, never by the wrapped subtraction.
    function automatic addr_map_t map_addr(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int unsigned depth
    );
        addr_map_t   m;
        logic [31:0] offset;
        offset = addr - base;
        m.idx  = offset >> 2;
        m.err  = (addr[1:0] != 2'b00) || (addr < base) || (m.idx >= depth);
        return m;
    endfunction

endpackage

// File: rtl/imem_responder_if.sv
// Fetch request/response channels plus the side preload port.
interface imem_responder_if;
    import imem_responder_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic [INST_W-1:0] resp_inst;
    logic              resp_err;
    logic              load_en;
    logic [31:0]       load_addr;
    logic [INST_W-1:0] load_data;

    modport master (
        output req_valid, req_addr, resp_ready, load_en, load_addr, load_data,
        input  req_ready, resp_valid, resp_inst, resp_err
    );

    modport slave (
        input  req_valid, req_addr, resp_ready, load_en, load_addr, load_data,
        output req_ready, resp_valid, resp_inst, resp_err
    );

endinterface

// File: rtl/imem_responder_array.sv
// Word-addressed instruction store: one preload write port and one registered
// read port that returns the pre-write contents on a same-edge collision.
module imem_array #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Contents survive reset so a program loaded under reset is kept.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/imem_responder.sv
// Memory end of the fetch interface: accepts a pc, waits LATENCY cycles and
// holds the instruction word (or an access fault) until the core takes it.
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = PC_RESET,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned LATENCY   = 1
) (
    input logic              clk,
    input logic              rst,
    imem_responder_if.slave  bus
);

    localparam int unsigned AW       = $clog2(DEPTH);
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    state_t            state;
    state_t            next_state;
    logic [3:0]        cnt;
    logic [31:0]       addr_q;
    logic              err_q;
    logic              accept;
    logic              handshake;
    logic              enter_resp;
    logic [31:0]       rd_addr;
    addr_map_t         rd_map;
    addr_map_t         ld_map;
    logic [INST_W-1:0] rd_data;
    logic              unused_idx_bits;

    assign accept     = bus.req_valid && (state == IDLE);
    assign handshake  = bus.resp_ready && (state == RESP);
    assign enter_resp = (state != RESP) && (next_state == RESP);

    // With LATENCY==1 the read is registered on the accept edge itself, before addr_q holds the pc.
    assign rd_addr = (state == IDLE) ? bus.req_addr : addr_q;
    assign rd_map  = map_addr(rd_addr, BASE_ADDR, DEPTH);
    assign ld_map  = map_addr(bus.load_addr, BASE_ADDR, DEPTH);

    assign unused_idx_bits = ^{rd_map.idx[31:AW], ld_map.idx[31:AW]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    next_state = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                if (handshake) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        unique case (state)
            IDLE:    bus.req_ready  = 1'b1;
            WAIT:    bus.req_ready  = 1'b0;
            RESP:    bus.resp_valid = 1'b1;
            default: bus.req_ready  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            addr_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                addr_q <= bus.req_addr;
                cnt    <= CNT_LOAD;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                err_q <= rd_map.err;
            end
        end
    end

    imem_array #(
        .DEPTH (DEPTH),
        .WIDTH (INST_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (bus.load_en && !ld_map.err),
        .waddr (ld_map.idx[AW-1:0]),
        .wdata (bus.load_data),
        .re    (enter_resp),
        .raddr (rd_map.idx[AW-1:0]),
        .rdata (rd_data)
    );

    assign bus.resp_err  = err_q;
    assign bus.resp_inst = err_q ? '0 : rd_data;

endmodule
